dsss_tx_sequencer: RTL and testbench

DSSS_TX_SEQUENCER -- requirements
Module: dsss_tx_sequencer

---
 rtl/dsss_tx_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dsss_tx_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dsss_tx_sequencer.sv
// DSSS transmit sequencer: walks carrier LUT phase, steps the PN generator per chip,
// and frames preamble + data bits with a valid/ready bit handshake.
module dsss_tx_sequencer #(
    parameter int unsigned SAMPLES_PER_CYCLE = 36,
    parameter int unsigned CYCLES_PER_CHIP   = 1,
    parameter int unsigned CHIPS_PER_BIT     = 7,
    parameter int unsigned PREAMBLE_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] frame_len,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       pn_chip,
    output logic       pn_advance,
    output logic [5:0] phase_addr,
    output logic       carrier_en,
    output logic       polarity,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int unsigned CYC_W  = (CYCLES_PER_CHIP > 1) ? $clog2(CYCLES_PER_CHIP) : 1;
    localparam int unsigned CHIP_W = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
    localparam logic [5:0]        PHASE_LAST = 6'(SAMPLES_PER_CYCLE - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(CYCLES_PER_CHIP - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST  = CHIP_W'(CHIPS_PER_BIT - 1);
    localparam logic [7:0]        PRE_LAST   = 8'(PREAMBLE_BITS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic [5:0]          phase_q, phase_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [7:0]          bit_q, bit_d;
    logic [7:0]          len_q, len_d;
    logic                cur_bit_q, cur_bit_d;
    logic                data_ready_q, data_ready_d;
    logic                pn_advance_q, pn_advance_d;
    logic                carrier_en_q, carrier_en_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                chip_end, bit_end, next_bit, active_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cyc_d     = cyc_q;
        chip_d    = chip_q;
        bit_d     = bit_q;
        len_d     = len_q;
        cur_bit_d = cur_bit_q;
        chip_end  = (phase_q == PHASE_LAST) && (cyc_q == CYC_LAST);
        bit_end   = chip_end && (chip_q == CHIP_LAST);
        // A starved handshake still advances the frame, sending a 0 bit.
        next_bit   = data_ready_q & data_valid & data_in;
        underrun_d = data_ready_q & ~data_valid;

        case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d   = PREAMBLE;
                    len_d     = frame_len;
                    phase_d   = '0;
                    cyc_d     = '0;
                    chip_d    = '0;
                    bit_d     = '0;
                    cur_bit_d = 1'b0;
                end
            end
            PREAMBLE, DATA: begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 6'd1;
                if (phase_q == PHASE_LAST)
                    cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
                if (chip_end)
                    chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + 1'b1;
                if (bit_end) begin
                    if (state_q == PREAMBLE && bit_q != PRE_LAST) begin
                        bit_d = bit_q + 8'd1;
                    end else if (state_q == PREAMBLE) begin
                        state_d   = DATA;
                        bit_d     = '0;
                        cur_bit_d = next_bit;
                    end else if (bit_q == len_q - 8'd1) begin
                        state_d   = DONE;
                        phase_d   = '0;
                        cyc_d     = '0;
                        chip_d    = '0;
                        bit_d     = '0;
                        cur_bit_d = 1'b0;
                    end else begin
                        bit_d     = bit_q + 8'd1;
                        cur_bit_d = next_bit;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            phase_d    = '0;
            cyc_d      = '0;
            chip_d     = '0;
            bit_d      = '0;
            cur_bit_d  = 1'b0;
            underrun_d = 1'b0;
        end

        // Registered outputs are decoded from next-state values so they line up with the counters.
        active_d      = (state_d == PREAMBLE) || (state_d == DATA);
        carrier_en_d  = active_d;
        busy_d        = (state_d != IDLE);
        frame_done_d  = (state_d == DONE);
        pn_advance_d  = active_d && (phase_d == PHASE_LAST) && (cyc_d == CYC_LAST);
        data_ready_d  = pn_advance_d && (chip_d == CHIP_LAST) &&
                        (((state_d == PREAMBLE) && (bit_d == PRE_LAST)) ||
                         ((state_d == DATA) && (({1'b0, bit_d} + 9'd1) < {1'b0, len_d})));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            cyc_q        <= '0;
            chip_q       <= '0;
            bit_q        <= '0;
            len_q        <= '0;
            cur_bit_q    <= 1'b0;
            data_ready_q <= 1'b0;
            pn_advance_q <= 1'b0;
            carrier_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cyc_q        <= cyc_d;
            chip_q       <= chip_d;
            bit_q        <= bit_d;
            len_q        <= len_d;
            cur_bit_q    <= cur_bit_d;
            data_ready_q <= data_ready_d;
            pn_advance_q <= pn_advance_d;
            carrier_en_q <= carrier_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign data_ready = data_ready_q;
    assign pn_advance = pn_advance_q;
    assign phase_addr = phase_q;
    assign carrier_en = carrier_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign polarity   = carrier_en_q & (cur_bit_q ^ pn_chip);
endmodule

// File: tb/tb_dsss_tx_sequencer.sv
// Scoreboard bench: stimulus queues expected handshake/done/underrun events with their
// cycle offset from the first active cycle; a negedge monitor pops and compares them.
module tb_dsss_tx_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, data_in, data_valid, pn_chip;
    logic [7:0] frame_len;
    logic       data_ready, pn_advance, carrier_en, polarity, busy, frame_done, underrun;
    logic [5:0] phase_addr;

    dsss_tx_sequencer #(
        .SAMPLES_PER_CYCLE(36),
        .CYCLES_PER_CHIP  (1),
        .CHIPS_PER_BIT    (7),
        .PREAMBLE_BITS    (2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .pn_chip(pn_chip), .pn_advance(pn_advance), .phase_addr(phase_addr),
        .carrier_en(carrier_en), .polarity(polarity), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int t; } ev_t;
    ev_t  sb[$];
    logic [1:0] resp[$];   // {valid, data} answered at each data_ready
    int   exp_bits[3];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   t      = 0;
    logic busy_prev = 1'b0;
    logic [2:0] lfsr = 3'b101;

    assign pn_chip = lfsr[0];
    always @(posedge clk) if (pn_advance) lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic push_ev(input int kind, input int tt);
        ev_t e;
        e.kind = kind;
        e.t    = tt;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_time", t, e.t);
        end
    endtask

    // Monitor: cycle offset, carrier/PN/polarity model, event scoreboard.
    always @(negedge clk) begin
        int bi;
        int eb;
        if (busy && !busy_prev) t = 0;
        else t = t + 1;
        busy_prev = busy;
        if (carrier_en) begin
            chk("phase_addr", int'(phase_addr), t % 36);
            chk("pn_advance", int'(pn_advance), int'((t % 36) == 35));
            bi = t / 252;
            eb = (bi < 2 || bi > 4) ? 0 : exp_bits[bi-2];
            chk("polarity", int'(polarity), eb ^ int'(pn_chip));
        end
        if (data_ready) check_ev(0);
        if (frame_done) begin
            check_ev(1);
            chk("done_carrier_en", int'(carrier_en), 0);
            chk("done_busy", int'(busy), 1);
            chk("done_phase", int'(phase_addr), 0);
        end
        if (underrun) check_ev(2);
    end

    // Bit source answering the handshake.
    always @(negedge clk) begin
        logic [1:0] r;
        #1;
        if (data_ready && resp.size() > 0) begin
            r = resp.pop_front();
            data_valid = r[1];
            data_in    = r[0];
        end else begin
            data_valid = 1'b0;
            data_in    = 1'b0;
        end
    end

    task automatic start_frame(input int len);
        @(posedge clk); #2;
        start = 1'b1;
        frame_len = 8'(len);
        @(posedge clk); #2;
        start = 1'b0;
        chk("first_busy", int'(busy), 1);
        chk("first_carrier_en", int'(carrier_en), 1);
        chk("first_phase", int'(phase_addr), 0);
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (t == target) break;
        end
    endtask

    task automatic wait_idle(input int exp_t);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (!busy) break;
        end
        chk("idle_reached", int'(busy), 0);
        chk("idle_time", t, exp_t);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_carrier_en"}, int'(carrier_en), 0);
        chk({tag, "_phase"}, int'(phase_addr), 0);
        chk({tag, "_data_ready"}, int'(data_ready), 0);
        chk({tag, "_pn_advance"}, int'(pn_advance), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_polarity"}, int'(polarity), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
        data_in = 1'b0; data_valid = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Frame of 3 valid bits 1,0,1; a stray start mid-frame must be ignored.
        exp_bits = '{1, 0, 1};
        resp.push_back(2'b11); resp.push_back(2'b10); resp.push_back(2'b11);
        push_ev(0, 503); push_ev(0, 755); push_ev(0, 1007); push_ev(1, 1260);
        start_frame(3);
        wait_t(300);
        start = 1'b1; frame_len = 8'd7;
        @(posedge clk); #2 start = 1'b0;
        wait_idle(1261);

        // Zero-length start in IDLE does nothing.
        @(posedge clk); #2 start = 1'b1; frame_len = 8'd0;
        @(posedge clk); #2 start = 1'b0;
        chk("len0_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #2 chk("len0_carrier_en", int'(carrier_en), 0);

        // Underrun on second data bit: sent as 0 despite data_in=1.
        exp_bits = '{1, 0, 1};
        resp.push_back(2'b11); resp.push_back(2'b01); resp.push_back(2'b11);
        push_ev(0, 503); push_ev(0, 755); push_ev(2, 756); push_ev(0, 1007); push_ev(1, 1260);
        start_frame(3);
        wait_idle(1261);

        // Abort at phase 17 of the first data bit.
        exp_bits = '{1, 1, 1};
        resp.push_back(2'b11);
        push_ev(0, 503);
        start_frame(3);
        wait_t(521);
        chk("abort_pre_phase", int'(phase_addr), 17);
        abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        check_all_zero("abort");
        repeat (20) @(posedge clk);

        // Reset mid-preamble, then a normal single-bit frame.
        exp_bits = '{1, 0, 0};
        start_frame(2);
        wait_t(100);
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        sb.delete();
        resp.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("post_reset_busy", int'(busy), 0);
        resp.push_back(2'b11);
        push_ev(0, 503); push_ev(1, 756);
        start_frame(1);
        wait_idle(757);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
